// File: rtl/pmi_pkg.sv
// Shared types and constants for the multi-port processor memory interface.
package pmi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } pmi_state_t;

    localparam int PMI_ARB_FIXED = 0;
    localparam int PMI_ARB_RR    = 1;

endpackage

// File: rtl/pmi_rr_arb.sv
// Combinational arbiter: fixed priority (port 0 highest) or round-robin
// starting one past last_grant.
module pmi_rr_arb
    import pmi_pkg::*;
#(
    parameter  int NPORTS = 2,
    parameter  int RR     = PMI_ARB_FIXED,
    localparam int IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     last_grant,
    output logic [NPORTS-1:0] gnt,
    output logic [IW-1:0]     gnt_idx,
    output logic              any_req
);

    assign any_req = |req;

    always_comb begin
        int unsigned start;
        int unsigned p;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        p       = 0;
        start   = (RR == PMI_ARB_RR) ? (32'(last_grant) + 32'd1) % 32'(NPORTS) : 32'd0;
        for (int unsigned i = 0; i < 32'(NPORTS); i++) begin
            p = (start + i) % 32'(NPORTS);
            if (!found && req[p]) begin
                found   = 1'b1;
                gnt[p]  = 1'b1;
                gnt_idx = IW'(p);
            end
        end
    end

endmodule

// File: rtl/pmi_mp.sv
// Multi-port memory interface: arbitrates NPORTS requesters onto one memory
// bus with byte-enabled writes, variable-latency ack and timeout error.
module pmi_mp
    import pmi_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR      = PMI_ARB_FIXED,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NPORTS-1:0]      req_rd,
    input  logic [NPORTS-1:0]      req_wr,
    input  logic [NPORTS*AW-1:0]   req_ad,
    input  logic [NPORTS*DW-1:0]   req_wdata,
    input  logic [NPORTS*DW/8-1:0] req_be,
    output logic [DW-1:0]          rdata,
    output logic [NPORTS-1:0]      mfc,
    output logic [NPORTS-1:0]      err,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_ad,
    output logic [DW-1:0]          mem_wdata,
    output logic [DW/8-1:0]        mem_be,
    input  logic                   mem_ack,
    input  logic [DW-1:0]          mem_rdata
);

    localparam int BW  = DW / 8;
    localparam int IW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int TCW = $clog2(TIMEOUT + 2);
    // BUSY runs TIMEOUT+2 cycles without ack before the error response
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT + 1);

    pmi_state_t        state_q, state_d;
    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic [NPORTS-1:0] gnt_q, gnt_d;
    logic [TCW-1:0]    cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_ad_q, mem_ad_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]     mem_be_q, mem_be_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [NPORTS-1:0] mfc_q, mfc_d;
    logic [NPORTS-1:0] err_q, err_d;

    logic [NPORTS-1:0] arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;

    pmi_rr_arb #(
        .NPORTS (NPORTS),
        .RR     (RR)
    ) u_arb (
        .req        (req_rd | req_wr),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .any_req    (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_ad_d     = mem_ad_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        rdata_d      = rdata_q;
        mfc_d        = '0;
        err_d        = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (arb_any) begin
                    last_grant_d = arb_idx;
                    gnt_d        = arb_gnt;
                    if (|(arb_gnt & req_rd & req_wr)) begin
                        state_d = RESP;
                        mfc_d   = arb_gnt;
                        err_d   = arb_gnt;
                    end else begin
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = |(arb_gnt & req_wr);
                        mem_ad_d    = req_ad[arb_idx*AW +: AW];
                        mem_wdata_d = req_wdata[arb_idx*DW +: DW];
                        mem_be_d    = (|(arb_gnt & req_wr)) ? req_be[arb_idx*BW +: BW] : '1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mfc_d     = gnt_q;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mfc_d     = gnt_q;
                    err_d     = gnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NPORTS - 1);
            gnt_q        <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_ad_q     <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            rdata_q      <= '0;
            mfc_q        <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_ad_q     <= mem_ad_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            rdata_q      <= rdata_d;
            mfc_q        <= mfc_d;
            err_q        <= err_d;
        end
    end

    assign rdata     = rdata_q;
    assign mfc       = mfc_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_ad    = mem_ad_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_pmi_mp.sv
// Directed bench for pmi_mp: one round-robin and one fixed-priority instance
// share the same stimulus; TIMEOUT=4 on both.
module tb_pmi_mp;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP-1:0]     req_rd = '0;
    logic [NP-1:0]     req_wr = '0;
    logic [NP*AW-1:0]  req_ad = '0;
    logic [NP*DW-1:0]  req_wdata = '0;
    logic [NP*BW-1:0]  req_be = '0;
    logic              mem_ack = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;

    logic [DW-1:0] rdata_a, rdata_b;
    logic [NP-1:0] mfc_a, mfc_b, err_a, err_b;
    logic          mem_req_a, mem_req_b, mem_we_a, mem_we_b;
    logic [AW-1:0] mem_ad_a, mem_ad_b;
    logic [DW-1:0] mem_wdata_a, mem_wdata_b;
    logic [BW-1:0] mem_be_a, mem_be_b;

    pmi_mp #(.NPORTS(NP), .AW(AW), .DW(DW), .RR(1), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr), .req_ad(req_ad),
        .req_wdata(req_wdata), .req_be(req_be), .rdata(rdata_a), .mfc(mfc_a), .err(err_a),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_ad(mem_ad_a), .mem_wdata(mem_wdata_a),
        .mem_be(mem_be_a), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    pmi_mp #(.NPORTS(NP), .AW(AW), .DW(DW), .RR(0), .TIMEOUT(TO)) dut_fx (
        .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr), .req_ad(req_ad),
        .req_wdata(req_wdata), .req_be(req_be), .rdata(rdata_b), .mfc(mfc_b), .err(err_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_ad(mem_ad_b), .mem_wdata(mem_wdata_b),
        .mem_be(mem_be_b), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        int          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        ack;
        int          k;
        logic [31:0] mrd;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [NP-1:0] oh;
        oh = '0;
        oh[v.port] = 1'b1;
        req_rd = '0;
        req_wr = '0;
        req_rd[v.port] = v.rd;
        req_wr[v.port] = v.wr;
        req_ad[v.port*AW +: AW] = v.addr;
        req_wdata[v.port*DW +: DW] = v.wdata;
        req_be[v.port*BW +: BW] = v.be;
        mem_ack = 1'b0;
        mem_rdata = v.mrd;
        tick();
        for (int c = 1; c < v.exp_cyc; c++) begin
            check($sformatf("v%0d_busy_req_rr_c%0d", idx, c), mem_req_a, 1);
            check($sformatf("v%0d_busy_req_fx_c%0d", idx, c), mem_req_b, 1);
            check($sformatf("v%0d_early_mfc_c%0d", idx, c), {mfc_a, mfc_b}, 0);
            if (c == 1) begin
                check($sformatf("v%0d_mem_we", idx), mem_we_a, v.wr);
                check($sformatf("v%0d_mem_ad", idx), mem_ad_a, v.addr);
                check($sformatf("v%0d_mem_be", idx), mem_be_a, v.wr ? v.be : 4'hF);
                if (v.wr) check($sformatf("v%0d_mem_wdata", idx), mem_wdata_a, v.wdata);
            end
            if (v.ack && c == 1 + v.k) mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        check($sformatf("v%0d_mfc_rr", idx), mfc_a, oh);
        check($sformatf("v%0d_mfc_fx", idx), mfc_b, oh);
        check($sformatf("v%0d_err_rr", idx), err_a, v.exp_err ? oh : '0);
        check($sformatf("v%0d_err_fx", idx), err_b, v.exp_err ? oh : '0);
        check($sformatf("v%0d_rdata_rr", idx), rdata_a, v.exp_rdata);
        check($sformatf("v%0d_rdata_fx", idx), rdata_b, v.exp_rdata);
        check($sformatf("v%0d_req_low", idx), {mem_req_a, mem_req_b}, 0);
        req_rd = '0;
        req_wr = '0;
        tick();
        check($sformatf("v%0d_mfc_one_cycle", idx), {mfc_a, mfc_b, err_a, err_b}, 0);
    endtask

    initial begin
        logic [NP-1:0] exp_rr, exp_fx;

        vecs[0] = '{rd:1, wr:0, port:0, addr:32'h0000_0010, wdata:32'h0, be:4'h0, ack:1, k:3,
                    mrd:32'hDEAD_BEEF, exp_cyc:5, exp_err:0, exp_rdata:32'hDEAD_BEEF};
        vecs[1] = '{rd:0, wr:1, port:1, addr:32'h0000_0020, wdata:32'h1234_5678, be:4'b0011, ack:1, k:0,
                    mrd:32'hBAD0_BAD0, exp_cyc:2, exp_err:0, exp_rdata:32'hDEAD_BEEF};
        vecs[2] = '{rd:1, wr:0, port:1, addr:32'h0000_0024, wdata:32'h0, be:4'h0, ack:1, k:1,
                    mrd:32'hCAFE_F00D, exp_cyc:3, exp_err:0, exp_rdata:32'hCAFE_F00D};
        vecs[3] = '{rd:1, wr:0, port:0, addr:32'h0000_0030, wdata:32'h0, be:4'h0, ack:0, k:0,
                    mrd:32'hBAD0_BAD0, exp_cyc:TO+3, exp_err:1, exp_rdata:32'hCAFE_F00D};
        vecs[4] = '{rd:1, wr:1, port:1, addr:32'h0000_0034, wdata:32'h0, be:4'hF, ack:0, k:0,
                    mrd:32'hBAD0_BAD0, exp_cyc:1, exp_err:1, exp_rdata:32'hCAFE_F00D};
        vecs[5] = '{rd:0, wr:1, port:0, addr:32'h0000_0000, wdata:32'hFFFF_0000, be:4'b1100, ack:1, k:4,
                    mrd:32'hBAD0_BAD0, exp_cyc:6, exp_err:0, exp_rdata:32'hCAFE_F00D};
        // ack in the last BUSY cycle before timeout must still win
        vecs[6] = '{rd:1, wr:0, port:1, addr:32'h0000_0044, wdata:32'h0, be:4'h0, ack:1, k:TO+1,
                    mrd:32'h55AA_55AA, exp_cyc:TO+3, exp_err:0, exp_rdata:32'h55AA_55AA};

        tick();
        tick();
        check("reset_mem_req", {mem_req_a, mem_req_b, mem_we_a, mem_we_b}, 0);
        check("reset_mem_ad", mem_ad_a, 0);
        check("reset_mem_wdata", mem_wdata_a, 0);
        check("reset_mem_be", {mem_be_a, mem_be_b}, 0);
        check("reset_rdata", rdata_a, 0);
        check("reset_mfc_err", {mfc_a, err_a, mfc_b, err_b}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // reset during BUSY: outputs clear asynchronously, no completion
        req_rd = 2'b01;
        req_ad[0 +: AW] = 32'h0000_0040;
        mem_ack = 1'b0;
        tick();
        check("rst_pre_busy", mem_req_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_req", {mem_req_a, mem_req_b}, 0);
        check("rst_async_ad", mem_ad_a, 0);
        check("rst_async_rdata", rdata_a, 0);
        check("rst_async_mfc", {mfc_a, mfc_b}, 0);
        req_rd = '0;
        tick();
        check("rst_no_mfc", {mfc_a, mfc_b, err_a, err_b}, 0);
        rst_n = 1'b1;

        // both ports re-request continuously with immediate ack
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_2222;
        req_rd = 2'b11;
        for (int c = 0; c < 12; c++) begin
            exp_rr = '0;
            exp_fx = '0;
            if (c % 3 == 2) begin
                exp_fx = 2'b01;
                exp_rr = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            end
            check($sformatf("cont_rr_mfc_c%0d", c), mfc_a, exp_rr);
            check($sformatf("cont_fx_mfc_c%0d", c), mfc_b, exp_fx);
            tick();
        end
        check("cont_err", {err_a, err_b}, 0);
        check("cont_rdata", rdata_a, 32'h1111_2222);
        req_rd = '0;
        mem_ack = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
